multiword_sub_ctrl: RTL and testbench
=====================================

// Module: multiword_sub_ctrl
// PURPOSE
//   Sequencer that computes WIDTH-bit A - B - Bin serially on one shared 4-bit
//   ripple-borrow subtractor slice (ripple_borrow_subtractor), one nibble per cycle, LSB first.
//   The borrow is carried between cycles in a register.
//   Valid/ready handshake on input and output. Sits between an operand source and
//   a result consumer where area matters more than throughput.
// PARAMETERS
//   WIDTH   16   operand/result width; must be a multiple of 4, >= 4
//   NIB     WIDTH/4 (localparam)   number of slice passes per operation
// PORTS
//   clk        in   1      rising-edge clock; sole clock domain
//   rst_n      in   1      synchronous, active-low reset
//   in_valid   in   1      operands on a/b/bin valid
//   in_ready   out  1      block can accept an operation (high only in IDLE)
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow-in to nibble 0
//   out_valid  out  1      diff/bout hold a completed result
//   out_ready  in   1      consumer takes result
//   diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//   bout       out  1      final borrow-out (1 when a < b + bin, unsigned)
//   busy       out  1      high in RUN
// BEHAVIOUR
//   Reset (rst_n low at a clk edge): state=IDLE, in_ready=1, out_valid=0, busy=0, diff=0,
//     bout=0, nibble index=0, borrow reg=0. Reset mid-RUN or mid-DONE discards the op.
//   FSM IDLE -> RUN -> DONE -> IDLE:
//   IDLE: in_ready=1. On an edge with in_valid=1: latch a, b, bin into op regs,
//     idx=0, borrow<=bin, go RUN. Inputs are ignored at all other times.
//   RUN: slice inputs = a_reg[4*idx+:4], b_reg[4*idx+:4], borrow reg. Each edge:
//     diff[4*idx+:4] <= slice D, borrow <= slice Bout, idx <= idx+1.
//     The edge that writes nibble NIB-1 also sets bout <= slice Bout and goes to DONE.
//   Latency: out_valid rises exactly NIB cycles after the accepting edge.
//   DONE: out_valid=1; diff/bout held stable. On an edge with out_ready=1: go IDLE,
//     out_valid<=0. If out_ready stays low, hold indefinitely.
//   No back-to-back issue. The earliest next accept is the edge after the DONE->IDLE edge.
//   diff is not a valid result outside DONE; upper nibbles keep the previous result during RUN.
//   idx has width clog2(NIB), min 1. It never exceeds NIB-1; no wrap inside an op.
//   WIDTH=4: RUN lasts exactly one cycle.
//   in_valid and out_ready asserted together in DONE: only out_ready acts.
// TESTING
//   1) WIDTH=16, a=0x1234, b=0x0235, bin=0 -> diff=0x0FFF, bout=0; out_valid 4 cycles after accept
//   2) a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1 (borrow ripples through all 4 passes)
//   3) a=0x8000, b=0x0000, bin=1 -> diff=0x7FFF, bout=0; a=0xFFFF, b=0xFFFF, bin=1 -> diff=0xFFFF, bout=1
//   4) Backpressure: out_ready=0 for 5 cycles in DONE -> diff/bout stable, in_ready=0;
//      new in_valid ignored; out_ready=1 -> IDLE next edge
//   5) rst_n=0 for one edge during nibble 2 of RUN -> next cycle IDLE, out_valid=0, diff=0;
//      next op a=5, b=3 -> diff=0x0002
//   6) WIDTH=4: a=0x3, b=0x5, bin=0 -> diff=0xE, bout=1, out_valid 1 cycle after accept

Source files
------------

// File: rtl/multiword_sub_ctrl_if.sv
// Operand/result handshake bundle for the serial multiword subtractor.
// The source/consumer side drives master; the sequencer takes slave.
interface multiword_sub_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, busy
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, busy
    );
endinterface

// File: rtl/multiword_sub_ctrl.sv
// Serial WIDTH-bit A - B - Bin on one shared 4-bit borrow slice,
// one nibble per cycle LSB first, valid/ready on both sides.
module ripple_borrow_subtractor (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       bin_i,
    output logic [3:0] d_o,
    output logic       bout_o
);
    logic [4:0] br;

    always_comb begin
        br    = '0;
        br[0] = bin_i;
        d_o   = '0;
        for (int i = 0; i < 4; i++) begin
            d_o[i]  = a_i[i] ^ b_i[i] ^ br[i];
            br[i+1] = (~a_i[i] & b_i[i]) |
                      (~(a_i[i] ^ b_i[i]) & br[i]);
        end
        bout_o = br[4];
    end
endmodule

module multiword_sub_ctrl #(
    parameter int WIDTH = 16
) (
    input logic               clk,
    input logic               rst_n,
    multiword_sub_ctrl_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;

    logic [3:0] a_nib, b_nib, s_d;
    logic       s_bout;
    logic       last_nib;

    // Constant-index mux keeps nibble selection width-exact for any WIDTH.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    assign last_nib = (idx_q == IW'(NIB - 1));

    ripple_borrow_subtractor u_slice (
        .a_i    (a_nib),
        .b_i    (b_nib),
        .bin_i  (brw_q),
        .d_o    (s_d),
        .bout_o (s_bout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        idx_d   = idx_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    brw_d   = bus.bin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NIB; i++) begin
                    if (idx_q == IW'(i)) diff_d[4*i +: 4] = s_d;
                end
                brw_d = s_bout;
                if (last_nib) begin
                    bout_d  = s_bout;
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            idx_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            idx_q   <= idx_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q == S_RUN);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
endmodule

// File: tb/tb_multiword_sub_ctrl.sv
// Random and directed checks of the serial subtractor at WIDTH 16 and 4
// against a plain signed-arithmetic reference.
module tb_multiword_sub_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multiword_sub_ctrl_if #(.WIDTH(16)) w16_if ();
    multiword_sub_ctrl_if #(.WIDTH(4))  w4_if ();

    multiword_sub_ctrl #(.WIDTH(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (w16_if.slave)
    );

    multiword_sub_ctrl #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (w4_if.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic iv,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic bin, input logic ordy);
        if (w == 16) begin
            w16_if.in_valid  = iv;
            w16_if.a         = a;
            w16_if.b         = b;
            w16_if.bin       = bin;
            w16_if.out_ready = ordy;
        end else begin
            w4_if.in_valid  = iv;
            w4_if.a         = a[3:0];
            w4_if.b         = b[3:0];
            w4_if.bin       = bin;
            w4_if.out_ready = ordy;
        end
    endtask

    task automatic observe(input int w, output logic rdy,
                           output logic ov, output logic bsy,
                           output logic bo, output logic [15:0] df);
        if (w == 16) begin
            rdy = w16_if.in_ready;
            ov  = w16_if.out_valid;
            bsy = w16_if.busy;
            bo  = w16_if.bout;
            df  = w16_if.diff;
        end else begin
            rdy = w4_if.in_ready;
            ov  = w4_if.out_valid;
            bsy = w4_if.busy;
            bo  = w4_if.bout;
            df  = {12'h000, w4_if.diff};
        end
    endtask

    // Issue one op; hold out_ready low for 'hold' cycles, optionally
    // poking in_valid with junk operands while the result waits.
    task automatic run_op(input int w, input logic [15:0] a,
                          input logic [15:0] b, input logic bin,
                          input int hold, input logic poke);
        int          m, d, k;
        logic        rdy, ov, bsy, bo;
        logic [15:0] df, exp_df;
        logic        exp_bo;
        m      = (1 << w) - 1;
        d      = (int'(a) & m) - (int'(b) & m) - int'(bin);
        exp_bo = (d < 0);
        exp_df = 16'(d & m);

        @(negedge clk);
        observe(w, rdy, ov, bsy, bo, df);
        chk("in_ready_idle", 32'(rdy), 32'd1);
        drive(w, 1'b1, a, b, bin, 1'b0);
        @(negedge clk);
        drive(w, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        observe(w, rdy, ov, bsy, bo, df);
        chk("busy_run", 32'(bsy), 32'd1);
        chk("in_ready_run", 32'(rdy), 32'd0);
        k = 0;
        while (!ov && k < 40) begin
            @(negedge clk);
            k++;
            observe(w, rdy, ov, bsy, bo, df);
        end
        chk("latency", 32'(k), 32'(w / 4));
        chk("diff", 32'(df), 32'(exp_df));
        chk("bout", 32'(bo), 32'(exp_bo));
        chk("busy_done", 32'(bsy), 32'd0);

        for (int h = 0; h < hold; h++) begin
            drive(w, poke, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
            @(negedge clk);
            observe(w, rdy, ov, bsy, bo, df);
            chk("hold_diff", 32'(df), 32'(exp_df));
            chk("hold_bout", 32'(bo), 32'(exp_bo));
            chk("hold_valid", 32'(ov), 32'd1);
            chk("hold_in_ready", 32'(rdy), 32'd0);
        end

        drive(w, poke, 16'($urandom), 16'($urandom), 1'b0, 1'b1);
        @(negedge clk);
        drive(w, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        observe(w, rdy, ov, bsy, bo, df);
        chk("release_valid", 32'(ov), 32'd0);
        chk("release_in_ready", 32'(rdy), 32'd1);
    endtask

    task automatic check_idle(input int w, input string tag);
        logic        rdy, ov, bsy, bo;
        logic [15:0] df;
        observe(w, rdy, ov, bsy, bo, df);
        chk({tag, "_in_ready"}, 32'(rdy), 32'd1);
        chk({tag, "_out_valid"}, 32'(ov), 32'd0);
        chk({tag, "_busy"}, 32'(bsy), 32'd0);
        chk({tag, "_diff"}, 32'(df), 32'd0);
        chk({tag, "_bout"}, 32'(bo), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(16, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(4, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_idle(16, "rst16");
        check_idle(4, "rst4");
        rst_n = 1'b1;

        run_op(16, 16'h1234, 16'h0235, 1'b0, 0, 1'b0);
        run_op(16, 16'h0000, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16, 16'h8000, 16'h0000, 1'b1, 1, 1'b0);
        run_op(16, 16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
        run_op(16, 16'hA5A5, 16'h1111, 1'b0, 5, 1'b1);
        run_op(4, 16'h0003, 16'h0005, 1'b0, 0, 1'b0);
        run_op(4, 16'h000F, 16'h000F, 1'b1, 2, 1'b1);

        begin : reset_mid_run
            logic        rdy, ov, bsy, bo;
            logic [15:0] df;
            @(negedge clk);
            drive(16, 1'b1, 16'hBEEF, 16'h1234, 1'b0, 1'b0);
            @(negedge clk);
            drive(16, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            repeat (2) @(negedge clk);
            observe(16, rdy, ov, bsy, bo, df);
            chk("pre_rst_busy", 32'(bsy), 32'd1);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check_idle(16, "midrun_rst");
        end
        run_op(16, 16'h0005, 16'h0003, 1'b0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(16, 16'($urandom), 16'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
            run_op(4, 16'($urandom), 16'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
